prg_loader: RTL and testbench

PRG_LOADER -- requirements
Module: prg_loader

---
 rtl/prg_loader.sv | 170 +++++++++++++++++
 tb/tb_prg_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_loader.sv
// Copies a finished SPI download from the download buffer into system RAM while holding the CPU.
// Define PRG_LOADER_HDR_EN to take the load address from a 2-byte little-endian header.
module prg_loader #(
  parameter logic [15:0] DEFAULT_ADDR = 16'h1001,
  parameter int unsigned BUF_BYTES    = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        downloading,
  input  logic [15:0] size,
  output logic [13:0] buf_addr,
  input  logic [7:0]  buf_dout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        done,
  output logic [15:0] load_addr,
  output logic [15:0] end_addr
);

  typedef enum logic [2:0] {IDLE, DL, HDR_LO, HDR_HI, RD, WR, FIN} state_t;

  localparam logic [15:0] BUF_MAX = 16'(BUF_BYTES);
`ifdef PRG_LOADER_HDR_EN
  localparam logic [15:0] HDR_LEN     = 16'd2;
  localparam state_t      FIRST_STATE = HDR_LO;
`else
  localparam logic [15:0] HDR_LEN     = 16'd0;
  localparam state_t      FIRST_STATE = RD;
`endif

  state_t      state, state_next;
  logic        dl_meta, dl_sync, dl_prev;
  logic        dl_rise, dl_fall;
  logic [15:0] len, len_clamped, idx, written;
  logic        rd_phase;

  // downloading comes from the SPI clock domain, so edges are only taken after two flops
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_meta <= 1'b0;
      dl_sync <= 1'b0;
      dl_prev <= 1'b0;
    end else begin
      dl_meta <= downloading;
      dl_sync <= dl_meta;
      dl_prev <= dl_sync;
    end
  end

  assign dl_rise     = dl_sync & ~dl_prev;
  assign dl_fall     = ~dl_sync & dl_prev;
  assign len_clamped = (size > BUF_MAX) ? BUF_MAX : size;
  assign buf_addr    = idx[13:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new download (rising edge) pre-empts any copy in progress
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dl_rise) state_next = DL;
      DL:      if (dl_fall) state_next = FIRST_STATE;
      HDR_LO: begin
        if (dl_rise)            state_next = DL;
        else if (len < 16'd2)   state_next = FIN;
        else if (rd_phase)      state_next = HDR_HI;
      end
      HDR_HI: begin
        if (dl_rise)            state_next = DL;
        else if (rd_phase)      state_next = RD;
      end
      RD: begin
        if (dl_rise)            state_next = DL;
        else if (idx == len)    state_next = FIN;
        else if (rd_phase)      state_next = WR;
      end
      WR: begin
        if (dl_rise)            state_next = DL;
        else if (mem_ack)       state_next = RD;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_hold = (state == DL) || (state == HDR_LO) || (state == HDR_HI) ||
               (state == RD) || (state == WR);
    mem_we   = (state == WR);
    done     = (state == FIN);
  end

  // rd_phase spends one extra cycle per read so buf_dout is taken two clocks after buf_addr moves
  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= 16'd0;
      idx       <= 16'd0;
      written   <= 16'd0;
      rd_phase  <= 1'b0;
      mem_addr  <= 16'd0;
      mem_data  <= 8'd0;
      load_addr <= 16'd0;
      end_addr  <= 16'd0;
    end else begin
      case (state)
        DL: begin
          if (dl_fall) begin
            len       <= len_clamped;
            idx       <= 16'd0;
            written   <= 16'd0;
            rd_phase  <= 1'b0;
            load_addr <= DEFAULT_ADDR;
          end
        end
        HDR_LO: begin
          if (!dl_rise) begin
            if (len < 16'd2) begin
              load_addr <= 16'd0;
              end_addr  <= 16'd0;
            end else if (rd_phase) begin
              load_addr[7:0] <= buf_dout;
              idx            <= idx + 16'd1;
              rd_phase       <= 1'b0;
            end else begin
              rd_phase <= 1'b1;
            end
          end
        end
        HDR_HI: begin
          if (!dl_rise) begin
            if (rd_phase) begin
              load_addr[15:8] <= buf_dout;
              idx             <= idx + 16'd1;
              rd_phase        <= 1'b0;
            end else begin
              rd_phase <= 1'b1;
            end
          end
        end
        RD: begin
          if (!dl_rise) begin
            if (idx == len) begin
              end_addr <= load_addr + written;
            end else if (rd_phase) begin
              mem_data <= buf_dout;
              mem_addr <= load_addr + idx - HDR_LEN;
              rd_phase <= 1'b0;
            end else begin
              rd_phase <= 1'b1;
            end
          end
        end
        WR: begin
          if (!dl_rise && mem_ack) begin
            idx     <= idx + 16'd1;
            written <= written + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader: random downloads scored against a behavioural copy model.
// Follows PRG_LOADER_HDR_EN the same way as the design.
module tb_prg_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        downloading;
  logic [15:0] size;
  logic [13:0] buf_addr;
  logic [7:0]  buf_dout;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ack;
  logic        cpu_hold;
  logic        done;
  logic [15:0] load_addr;
  logic [15:0] end_addr;

  int errors = 0;
  int checks = 0;

  logic [7:0]  buf_mem [0:16383];
  logic [15:0] obs_addr[$];
  logic [7:0]  obs_data[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [15:0] exp_load, exp_end;
  int          obs_base, done_base;
  int          done_cnt = 0;
  int          ack_delay = 0;
  int          we_cnt = 0;
  int          cyc = 0;
  logic        ack_noise = 1'b0;
  logic        held = 1'b0;
  logic [15:0] held_addr;
  logic [7:0]  held_data;
  int          prev_acc_cyc = 0;
  logic        prev_acc_valid = 1'b0;

  always #5 clk = ~clk;

  prg_loader dut (
    .clk        (clk),
    .reset      (reset),
    .downloading(downloading),
    .size       (size),
    .buf_addr   (buf_addr),
    .buf_dout   (buf_dout),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .load_addr  (load_addr),
    .end_addr   (end_addr)
  );

  // Buffer RAM with one clock of read latency behind the loader's registered address
  always @(posedge clk) begin
    buf_dout  <= buf_mem[buf_addr];
    ack_noise <= 1'($urandom);
    cyc       <= cyc + 1;
    if (mem_we && !mem_ack) we_cnt <= we_cnt + 1;
    else                    we_cnt <= 0;
  end

  assign mem_ack = mem_we ? (we_cnt >= ack_delay) : ack_noise;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write/done monitor; a write lands on the edge after a cycle with mem_we and mem_ack high
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
      prev_acc_valid = 1'b0;
    end else begin
      if (downloading || !cpu_hold) prev_acc_valid = 1'b0;
      if (done) begin
        done_cnt++;
        checkOutput("hold_low_at_done", 32'(cpu_hold), 32'd0);
      end
      if (mem_we) begin
        checkOutput("hold_during_we", 32'(cpu_hold), 32'd1);
        if (held) begin
          checkOutput("addr_stable", 32'(mem_addr), 32'(held_addr));
          checkOutput("data_stable", 32'(mem_data), 32'(held_data));
        end
        if (mem_ack) begin
          obs_addr.push_back(mem_addr);
          obs_data.push_back(mem_data);
          if (prev_acc_valid)
            checkOutput("throughput_gap", 32'(cyc - prev_acc_cyc), 32'(3 + ack_delay));
          prev_acc_valid = 1'b1;
          prev_acc_cyc   = cyc;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_addr = mem_addr;
          held_data = mem_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Reference: clamp, optional header, then a straight copy of the remaining bytes
  function automatic void buildModel(input int sz);
    int len;
    int first;
    len = (sz > 16384) ? 16384 : sz;
    exp_addr.delete();
    exp_data.delete();
`ifdef PRG_LOADER_HDR_EN
    first = 2;
    if (len < 2) begin
      exp_load = 16'h0000;
      len = first;
    end else begin
      exp_load = {buf_mem[1], buf_mem[0]};
    end
`else
    first = 0;
    exp_load = 16'h1001;
`endif
    for (int i = first; i < len; i++) begin
      exp_addr.push_back(16'(exp_load + 16'(i - first)));
      exp_data.push_back(buf_mem[i]);
    end
    exp_end = 16'(exp_load + 16'(exp_addr.size()));
  endfunction

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) buf_mem[i] = 8'($urandom);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_buf_addr"}, 32'(buf_addr), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_load_addr"}, 32'(load_addr), 32'd0);
    checkOutput({tag, "_end_addr"}, 32'(end_addr), 32'd0);
  endtask

  task automatic startDownload(input int sz, input int delay);
    @(negedge clk);
    ack_delay   = delay;
    downloading = 1'b1;
    obs_base    = obs_addr.size();
    done_base   = done_cnt;
    repeat (4) @(negedge clk);
    size        = 16'(sz);
    downloading = 1'b0;
    buildModel(sz);
  endtask

  task automatic finishDownload(input string tag);
    int limit;
    int n_obs;
    limit = 200 + 8 * (exp_addr.size() + 2);
    for (int c = 0; c < limit && done_cnt == done_base; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
    n_obs = obs_addr.size() - obs_base;
    checkOutput({tag, "_write_count"}, 32'(n_obs), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < n_obs; i++) begin
      checkOutput({tag, "_wr_addr"}, 32'(obs_addr[obs_base + i]), 32'(exp_addr[i]));
      checkOutput({tag, "_wr_data"}, 32'(obs_data[obs_base + i]), 32'(exp_data[i]));
    end
    checkOutput({tag, "_load_addr"}, 32'(load_addr), 32'(exp_load));
    checkOutput({tag, "_end_addr"}, 32'(end_addr), 32'(exp_end));
    checkOutput({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_we_after"}, 32'(mem_we), 32'd0);
  endtask

  task automatic applyStimulus(input int sz, input int delay, input string tag);
    startDownload(sz, delay);
    finishDownload(tag);
  endtask

  initial begin
    int n;
    int we_seen;
    int hold_low_seen;
    reset       = 1'b1;
    downloading = 1'b0;
    size        = 16'd0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

`ifdef PRG_LOADER_HDR_EN
    buf_mem[0] = 8'h01; buf_mem[1] = 8'h10; buf_mem[2] = 8'hAA;
    buf_mem[3] = 8'hBB; buf_mem[4] = 8'hCC;
    applyStimulus(5, 0, "hdr_basic");
    buf_mem[0] = 8'hFF; buf_mem[1] = 8'hFF; buf_mem[2] = 8'h11;
    buf_mem[3] = 8'h22; buf_mem[4] = 8'h33;
    applyStimulus(5, 0, "hdr_wrap");
    applyStimulus(1, 0, "hdr_short");
`else
    buf_mem[0] = 8'h5A; buf_mem[1] = 8'hA5;
    applyStimulus(2, 0, "plain_two");
`endif
    applyStimulus(0, 0, "zero_len");

    fillRandom(8);
    applyStimulus(8, 3, "slow_ack");

    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(0, 20);
      fillRandom(n);
      applyStimulus(n, $urandom_range(0, 3), "random");
    end

    // Abort: a new download arrives after the second write
    fillRandom(10);
    startDownload(10, 0);
    for (int c = 0; c < 300 && (obs_addr.size() - obs_base) < 2; c++) @(negedge clk);
    downloading = 1'b1;
    repeat (4) @(negedge clk);
    we_seen = 0;
    hold_low_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (!cpu_hold) hold_low_seen++;
    end
    checkOutput("abort_we_low", 32'(we_seen), 32'd0);
    checkOutput("abort_hold_kept", 32'(hold_low_seen), 32'd0);
    checkOutput("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    fillRandom(12);
    applyStimulus(12, 1, "after_abort");

    // Reset while a write is waiting for acknowledge
    fillRandom(8);
    startDownload(8, 3);
    for (int c = 0; c < 300 && !mem_we; c++) @(negedge clk);
    checkOutput("mid_we_reached", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkReset("mid_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    fillRandom(9);
    applyStimulus(9, 0, "after_reset");

    // Oversized download is clamped to the buffer capacity
    fillRandom(16384);
    applyStimulus(16'h4005, 0, "clamp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
